// File: rtl/cla_operand_sequencer.sv
// Registered operand sequencer for the EX-stage CLA adder.
// Single-word ops pick one operand per cycle; multi-word ops latch a
// WORDS x WIDTH operand and issue it low word first, chaining the adder carry.
module cla_operand_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned WORDS = 2,
   parameter int unsigned IDX_W = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             sel,
   input  logic                   double,
   input  logic [WIDTH-1:0]       inA,
   input  logic [WIDTH*WORDS-1:0] inB,
   input  logic                   cla_cout,
   output logic [WIDTH-1:0]       out,
   output logic                   out_cin,
   output logic                   out_valid,
   output logic [IDX_W-1:0]       word_idx,
   output logic                   out_last
);

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
   localparam bit               MULTI    = (WORDS > 1);

   state_t                        state;
   state_t                        state_d;
   logic [WORDS-1:0][WIDTH-1:0]   hold;
   logic [WORDS-1:0][WIDTH-1:0]   hold_d;
   logic [IDX_W-1:0]              cnt;
   logic [IDX_W-1:0]              cnt_d;
   logic [WIDTH-1:0]              out_d;
   logic                          out_cin_d;
   logic                          out_valid_d;
   logic                          out_last_d;
   logic [IDX_W-1:0]              word_idx_d;
   logic                          accept;
   logic                          at_last;

   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign at_last  = (cnt == LAST_IDX);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Next-state: a multi-word accept enters ISSUE, the final word returns to IDLE
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept && double && MULTI) state_d = ISSUE;
         ISSUE:   if (at_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs, word counter and holding register
   always_comb begin
      out_d       = out;
      out_cin_d   = out_cin;
      word_idx_d  = word_idx;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      cnt_d       = cnt;
      hold_d      = hold;
      case (state)
         IDLE: begin
            if (accept) begin
               out_valid_d = 1'b1;
               out_cin_d   = 1'b0;
               word_idx_d  = '0;
               if (double) begin
                  hold_d     = inB;
                  out_d      = inB[WIDTH-1:0];
                  out_last_d = !MULTI;
                  cnt_d      = MULTI ? IDX_W'(1) : '0;
               end else begin
                  out_d      = (sel == 3'b000) ? inB[WIDTH-1:0] : inA;
                  out_last_d = 1'b1;
               end
            end
         end
         ISSUE: begin
            out_d       = hold[cnt];
            out_cin_d   = cla_cout;
            word_idx_d  = cnt;
            out_valid_d = 1'b1;
            out_last_d  = at_last;
            if (!at_last) cnt_d = cnt + IDX_W'(1);
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         out_cin   <= 1'b0;
         out_valid <= 1'b0;
         word_idx  <= '0;
         out_last  <= 1'b0;
         cnt       <= '0;
         hold      <= '0;
      end else begin
         out       <= out_d;
         out_cin   <= out_cin_d;
         out_valid <= out_valid_d;
         word_idx  <= word_idx_d;
         out_last  <= out_last_d;
         cnt       <= cnt_d;
         hold      <= hold_d;
      end
   end

endmodule

// File: tb/tb_cla_operand_sequencer.sv
// Bench for cla_operand_sequencer: a 2-word and a 4-word instance share the
// stimulus; a queue-style model predicts every output on every cycle.
module tb_cla_operand_sequencer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         double;
   logic [2:0]   sel;
   logic [31:0]  inA;
   logic [127:0] inB;
   logic [31:0]  addend;

   logic         ready2, cin2, valid2, last2, cout2;
   logic [31:0]  out2;
   logic [0:0]   idx2;
   logic         ready4, cin4, valid4, last4, cout4;
   logic [31:0]  out4;
   logic [1:0]   idx4;
   logic [32:0]  sum2, sum4;

   always #5 clk = ~clk;

   // adder models: the other operand is a bench-driven addend
   assign sum2  = 33'(out2) + 33'(addend) + 33'(cin2);
   assign sum4  = 33'(out4) + 33'(addend) + 33'(cin4);
   assign cout2 = sum2[32];
   assign cout4 = sum4[32];

   cla_operand_sequencer #(.WIDTH(32), .WORDS(2), .IDX_W(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready2),
      .sel(sel), .double(double), .inA(inA), .inB(inB[63:0]),
      .cla_cout(cout2), .out(out2), .out_cin(cin2), .out_valid(valid2),
      .word_idx(idx2), .out_last(last2));

   cla_operand_sequencer #(.WIDTH(32), .WORDS(4), .IDX_W(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ready4),
      .sel(sel), .double(double), .inA(inA), .inB(inB),
      .cla_cout(cout4), .out(out4), .out_cin(cin4), .out_valid(valid4),
      .word_idx(idx4), .out_last(last4));

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model, index 0 = 2-word instance, 1 = 4-word instance
   logic [31:0] m_out   [2] = '{default: '0};
   logic        m_cin   [2] = '{default: 1'b0};
   logic        m_valid [2] = '{default: 1'b0};
   logic        m_last  [2] = '{default: 1'b0};
   int          m_idx   [2] = '{default: 0};
   logic [31:0] pend    [2][4];
   int          npend   [2] = '{default: 0};
   int          rd      [2] = '{default: 0};
   logic [32:0] m_sum;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int nw;
         nw    = (i == 0) ? 2 : 4;
         m_sum = 33'(m_out[i]) + 33'(addend) + 33'(m_cin[i]);
         if (!rst_n) begin
            m_out[i] = '0; m_cin[i] = 1'b0; m_valid[i] = 1'b0;
            m_last[i] = 1'b0; m_idx[i] = 0; npend[i] = 0; rd[i] = 0;
         end else if (npend[i] != 0) begin
            m_out[i]   = pend[i][rd[i]];
            rd[i]      = rd[i] + 1;
            npend[i]   = npend[i] - 1;
            m_cin[i]   = m_sum[32];
            m_idx[i]   = m_idx[i] + 1;
            m_last[i]  = (npend[i] == 0);
            m_valid[i] = 1'b1;
         end else if (in_valid) begin
            m_valid[i] = 1'b1;
            m_cin[i]   = 1'b0;
            m_idx[i]   = 0;
            if (double) begin
               for (int k = 1; k < nw; k++) pend[i][k-1] = inB[k*32 +: 32];
               rd[i]     = 0;
               npend[i]  = nw - 1;
               m_out[i]  = inB[31:0];
               m_last[i] = (nw == 1);
            end else begin
               m_out[i]  = (sel == 3'b000) ? inB[31:0] : inA;
               m_last[i] = 1'b1;
            end
         end else begin
            m_valid[i] = 1'b0;
            m_last[i]  = 1'b0;
         end
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("d2.out",   128'(out2),   128'(m_out[0]));
         chk("d2.cin",   128'(cin2),   128'(m_cin[0]));
         chk("d2.valid", 128'(valid2), 128'(m_valid[0]));
         chk("d2.last",  128'(last2),  128'(m_last[0]));
         chk("d2.idx",   128'(idx2),   128'(m_idx[0]));
         chk("d2.ready", 128'(ready2), 128'(npend[0] == 0));
         chk("d4.out",   128'(out4),   128'(m_out[1]));
         chk("d4.cin",   128'(cin4),   128'(m_cin[1]));
         chk("d4.valid", 128'(valid4), 128'(m_valid[1]));
         chk("d4.last",  128'(last4),  128'(m_last[1]));
         chk("d4.idx",   128'(idx4),   128'(m_idx[1]));
         chk("d4.ready", 128'(ready4), 128'(npend[1] == 0));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      in_valid = 1'b0;
      double   = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; double = 1'b0; sel = 3'b000;
      inA = '0; inB = '0; addend = '0;
      step();
      step();
      chk_en = 1'b1;
      chk("rst.valid", 128'(valid2), 128'(0));
      chk("rst.out",   128'(out2),   128'(0));
      chk("rst.ready", 128'(ready2), 128'(1));
      rst_n = 1'b1;

      // single op, inB path
      in_valid = 1'b1; double = 1'b0; sel = 3'b000;
      inB = 128'h0000_0000_DEAD_BEEF; inA = 32'h1234_5678;
      step();
      chk("single.out",   128'(out2),   128'h0000_0000_DEAD_BEEF);
      chk("single.valid", 128'(valid2), 128'(1));
      chk("single.last",  128'(last2),  128'(1));
      chk("single.cin",   128'(cin2),   128'(0));
      chk("single.ready", 128'(ready2), 128'(1));

      // back-to-back singles, inA path
      sel = 3'b001;
      for (int k = 1; k <= 3; k++) begin
         inA = 32'(k);
         step();
         chk("b2b.out",   128'(out2),   128'(k));
         chk("b2b.valid", 128'(valid2), 128'(1));
         chk("b2b.ready", 128'(ready2), 128'(1));
      end
      in_valid = 1'b0;
      step();
      chk("hold.valid", 128'(valid2), 128'(0));
      chk("hold.out",   128'(out2),   128'(3));

      // double with carry chained from word 0 into word 1
      in_valid = 1'b1; double = 1'b1; sel = 3'b000;
      inB = 128'h0000_0001_FFFF_FFFF; addend = 32'd1;
      step();
      in_valid = 1'b0; double = 1'b0;
      chk("dbl.w0.out",   128'(out2),   128'hFFFF_FFFF);
      chk("dbl.w0.cin",   128'(cin2),   128'(0));
      chk("dbl.w0.idx",   128'(idx2),   128'(0));
      chk("dbl.w0.last",  128'(last2),  128'(0));
      chk("dbl.w0.ready", 128'(ready2), 128'(0));
      step();
      chk("dbl.w1.out",   128'(out2),   128'(1));
      chk("dbl.w1.cin",   128'(cin2),   128'(1));
      chk("dbl.w1.idx",   128'(idx2),   128'(1));
      chk("dbl.w1.last",  128'(last2),  128'(1));
      chk("dbl.w1.ready", 128'(ready2), 128'(1));
      idle_cycles(4);

      // sel ignored on double, inB changes during ISSUE have no effect
      in_valid = 1'b1; double = 1'b1; sel = 3'b101; inA = 32'hBAD0_BAD0;
      inB = 128'h0000_0000_0000_0000_CAFE_0002_CAFE_0001; addend = '0;
      step();
      in_valid = 1'b0; double = 1'b0; inB = {4{32'hFFFF_FFFF}};
      chk("latch.w0", 128'(out2), 128'hCAFE_0001);
      step();
      chk("latch.w1",   128'(out2),  128'hCAFE_0002);
      chk("latch.last", 128'(last2), 128'(1));
      idle_cycles(4);

      // reset right after a double accept aborts the op
      in_valid = 1'b1; double = 1'b1;
      inB = 128'h0000_0000_0000_0000_5555_0002_5555_0001;
      step();
      in_valid = 1'b0; double = 1'b0;
      chk("abort.w0", 128'(out2), 128'h5555_0001);
      rst_n = 1'b0;
      step();
      chk("abort.out",    128'(out2),   128'(0));
      chk("abort.valid",  128'(valid2), 128'(0));
      chk("abort.idx",    128'(idx2),   128'(0));
      chk("abort.ready",  128'(ready2), 128'(1));
      chk("abort.ready4", 128'(ready4), 128'(1));
      rst_n = 1'b1;
      step();
      chk("abort.nomore", 128'(valid2), 128'(0));
      chk("abort.out2",   128'(out2),   128'(0));

      // four-word op on the 4-word instance
      in_valid = 1'b1; double = 1'b1;
      inB = 128'h4444_4444_3333_3333_2222_2222_1111_1111; addend = '0;
      for (int k = 0; k < 4; k++) begin
         step();
         in_valid = 1'b0; double = 1'b0;
         chk("w4.out",   128'(out4),   128'(32'h1111_1111 * 32'(k + 1)));
         chk("w4.idx",   128'(idx4),   128'(k));
         chk("w4.last",  128'(last4),  128'(k == 3));
         chk("w4.ready", 128'(ready4), 128'(k == 3));
         chk("w4.cin",   128'(cin4),   128'(0));
      end
      idle_cycles(2);

      // randomized traffic with occasional resets
      for (int n = 0; n < 3000; n++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         in_valid = ($urandom_range(0, 3) != 0);
         double   = 1'($urandom_range(0, 1));
         sel      = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'($urandom_range(1, 7));
         inA      = $urandom;
         inB      = {$urandom, $urandom, $urandom, $urandom};
         addend   = $urandom;
         step();
      end
      rst_n = 1'b1;
      idle_cycles(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
